// File: rtl/i2s_tx.sv
// I2S transmitter: serializes signed 16-bit L/R samples into BCLK/LRCLK/SDATA,
// with one pending sample buffer in front of the active frame registers.
module i2s_tx #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Enable,
    input  logic signed [15:0] sample_l,
    input  logic signed [15:0] sample_r,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               BCLK,
    output logic               LRCLK,
    output logic               SDATA,
    output logic               frame_start,
    output logic               underrun
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt, pos;
    logic             pend_valid;
    logic [15:0]      pend_l, pend_r, active_l, active_r, word;
    logic [3:0]       bidx;
    logic             run, div_wrap, fall, boundary, xfer, lr_nxt, sdata_nxt;

    // LRCLK/SDATA are computed from the bit position reached on this falling edge.
    always_comb begin
        run       = Enable && (state == RUN);
        div_wrap  = (div_cnt == DIV_W'(BCLK_DIV - 1));
        fall      = run && div_wrap && BCLK;
        bit_nxt   = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
        boundary  = fall && (bit_cnt == BIT_W'(FRAME_BITS - 1));
        lr_nxt    = (bit_nxt >= BIT_W'(SLOT_BITS));
        pos       = lr_nxt ? bit_nxt - BIT_W'(SLOT_BITS) : bit_nxt;
        word      = lr_nxt ? active_r : active_l;
        bidx      = 4'(5'd16 - 5'(pos));
        sdata_nxt = (pos >= BIT_W'(1)) && (pos <= BIT_W'(16)) && word[bidx];
        xfer      = sample_valid && sample_ready;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            BCLK         <= 1'b0;
            LRCLK        <= 1'b0;
            SDATA        <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            pend_valid   <= 1'b0;
            sample_ready <= 1'b1;
            pend_l       <= '0;
            pend_r       <= '0;
            active_l     <= '0;
            active_r     <= '0;
        end else begin
            frame_start <= boundary;
            underrun    <= 1'b0;

            // An empty buffer at the boundary lets a same-cycle transfer go straight to active.
            if (boundary) begin
                if (pend_valid) begin
                    active_l     <= pend_l;
                    active_r     <= pend_r;
                    pend_valid   <= 1'b0;
                    sample_ready <= 1'b1;
                end else if (xfer) begin
                    active_l <= sample_l;
                    active_r <= sample_r;
                end else begin
                    underrun <= 1'b1;
                end
            end else if (xfer) begin
                pend_l       <= sample_l;
                pend_r       <= sample_r;
                pend_valid   <= 1'b1;
                sample_ready <= 1'b0;
            end

            if (!Enable) begin
                state   <= IDLE;
                div_cnt <= '0;
                bit_cnt <= '0;
                BCLK    <= 1'b0;
                LRCLK   <= 1'b0;
                SDATA   <= 1'b0;
            end else if (state == IDLE) begin
                state <= RUN;
            end else if (div_wrap) begin
                div_cnt <= '0;
                BCLK    <= ~BCLK;
                if (BCLK) begin
                    bit_cnt <= bit_nxt;
                    LRCLK   <= lr_nxt;
                    SDATA   <= sdata_nxt;
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx against a time-based reference model: bit position,
// slot and BCLK phase are derived arithmetically from clocks elapsed since RUN entry.
module tb_i2s_tx;
    localparam int DIV        = 4;
    localparam int SLOT       = 32;
    localparam int FRAME_BITS = 2 * SLOT;
    localparam int FRAME_CLK  = 2 * DIV * FRAME_BITS;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic [15:0] sample_l = '0, sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, BCLK, LRCLK, SDATA, frame_start, underrun;

    i2s_tx #(.BCLK_DIV(DIV), .SLOT_BITS(SLOT)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 Clk = ~Clk;

    int total = 0, bad = 0;

    // reference model state
    bit          m_run = 0, m_pv = 0;
    int          t = 0;
    logic [15:0] m_pl = '0, m_pr = '0, m_al = '0, m_ar = '0;
    bit          e_bclk, e_lr, e_sd, e_fs, e_ur;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pv = 0; t = 0;
        m_pl = '0; m_pr = '0; m_al = '0; m_ar = '0;
        e_bclk = 0; e_lr = 0; e_sd = 0; e_fs = 0; e_ur = 0;
    endtask

    task automatic model_step();
        bit xfer, bnd;
        int f, b, p;
        logic [15:0] w;
        xfer = sample_valid && !m_pv;
        bnd  = 0;
        if (Enable) begin
            if (!m_run) begin m_run = 1; t = 0; end
            else begin t++; bnd = (t % FRAME_CLK == 0); end
        end else begin
            m_run = 0; t = 0;
        end
        e_fs = bnd; e_ur = 0;
        if (bnd) begin
            if (m_pv) begin m_al = m_pl; m_ar = m_pr; m_pv = 0; end
            else if (xfer) begin m_al = sample_l; m_ar = sample_r; end
            else e_ur = 1;
        end else if (xfer) begin
            m_pl = sample_l; m_pr = sample_r; m_pv = 1;
        end
        if (m_run) begin
            f      = t / (2 * DIV);
            b      = f % FRAME_BITS;
            e_lr   = (b >= SLOT);
            p      = b % SLOT;
            w      = e_lr ? m_ar : m_al;
            e_sd   = (p >= 1 && p <= 16) ? w[16 - p] : 1'b0;
            e_bclk = ((t / DIV) % 2) == 1;
        end else begin
            e_bclk = 0; e_lr = 0; e_sd = 0;
        end
    endtask

    task automatic check_all();
        chk("bclk",        BCLK,         e_bclk);
        chk("lrclk",       LRCLK,        e_lr);
        chk("sdata",       SDATA,        e_sd);
        chk("frame_start", frame_start,  e_fs);
        chk("underrun",    underrun,     e_ur);
        chk("ready",       sample_ready, !m_pv);
    endtask

    // Called just after a negedge: drive, take one clock, check at the next negedge.
    task automatic cycle(input logic en, input logic v, input logic [15:0] l, input logic [15:0] r,
                         output bit acc);
        Enable = en; sample_valid = v; sample_l = l; sample_r = r;
        #1;
        acc = v && sample_ready;
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check_all();
    endtask

    int          n, lrcnt, idx;
    bit          acc;
    logic [63:0] cap;
    logic [15:0] vl [4];
    logic [15:0] vr [4];

    initial begin
        model_reset();
        #1 Reset = 1'b0;
        #2;
        check_all();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

        // idle for 100 cycles
        for (int i = 0; i < 100; i++) cycle(0, 0, 16'h0, 16'h0, acc);

        // sample offered in IDLE, then two frames
        cycle(0, 1, 16'h8001, 16'h7FFE, acc);
        lrcnt = 0; cap = '0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            cycle(1, 0, 16'h0, 16'h0, acc);
            if (i >= FRAME_CLK) begin
                if (LRCLK) lrcnt++;
                if (i % (2 * DIV) == DIV) cap = {cap[62:0], SDATA};
            end
        end
        chk("lr_high_cycles", lrcnt, 256);
        chk("frame2_bits", cap, {1'b0, 16'h8001, 15'h0, 1'b0, 16'h7FFE, 15'h0});

        // stream 4 samples with valid held high
        vl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        vr = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        idx = 0;
        for (int i = 0; i < 6 * FRAME_CLK; i++) begin
            cycle(1, idx < 4, (idx < 4) ? vl[idx] : 16'h0, (idx < 4) ? vr[idx] : 16'h0, acc);
            if (acc) idx++;
        end
        chk("stream_accepted", idx, 4);

        // starve after 1234/ABCD
        n = 0; acc = 0;
        while (!acc && n < 2 * FRAME_CLK) begin cycle(1, 1, 16'h1234, 16'hABCD, acc); n++; end
        chk("starve_accept", acc, 1);
        for (int i = 0; i < 3 * FRAME_CLK; i++) cycle(1, 0, 16'h0, 16'h0, acc);

        // drop Enable mid right slot with a sample pending, resume 50 cycles later
        n = 0;
        while ((((t / (2 * DIV)) % FRAME_BITS) != 40) && n < 2 * FRAME_CLK) begin
            cycle(1, 0, 16'h0, 16'h0, acc); n++;
        end
        chk("wait_right_slot", (n < 2 * FRAME_CLK), 1);
        cycle(1, 1, 16'h5555, 16'hA5A5, acc);
        for (int i = 0; i < 50; i++) cycle(0, 0, 16'h0, 16'h0, acc);
        for (int i = 0; i < 2 * FRAME_CLK + 20; i++) cycle(1, 0, 16'h0, 16'h0, acc);

        // random traffic with occasional Enable drops
        Enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic en;
            en = ($urandom_range(0, 299) == 0) ? ~Enable : Enable;
            if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            cycle(en, $urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom), acc);
        end

        // async reset mid-frame with a sample pending
        n = 0; acc = 0;
        while (!acc && n < 2 * FRAME_CLK) begin cycle(1, 1, 16'hCAFE, 16'hBEEF, acc); n++; end
        for (int i = 0; i < 300; i++) cycle(1, 0, 16'h0, 16'h0, acc);
        if (!m_pv) cycle(1, 1, 16'h0F0F, 16'hF0F0, acc);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < FRAME_CLK + 20; i++) cycle(1, 0, 16'h0, 16'h0, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio output serializer directly downstream of the biquad filter stage.
- Accepts signed 16-bit left/right samples through a valid/ready handshake and drives an I2S DAC: BCLK, LRCLK and SDATA, all generated from the system clock.
- One pending sample buffer plus an active frame register, so the producer can deliver the next sample while the current frame is shifting out.

Parameters:
- BCLK_DIV, 4: Clk cycles per BCLK half-period; BCLK period = 2*BCLK_DIV Clk; legal ≥ 1.
- SLOT_BITS, 32: BCLK periods per channel slot; frame = 2*SLOT_BITS BCLK; legal ≥ 17.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Enable  in  1  run serializer; low = idle.
- sample_l  in  16  signed left sample, two's complement.
- sample_r  in  16  signed right sample.
- sample_valid  in  1  producer offers sample_l/sample_r.
- sample_ready  out  1  pending buffer empty; transfer occurs when valid && ready.
- BCLK  out  1  bit clock.
- LRCLK  out  1  word select; 0 = left slot, 1 = right slot.
- SDATA  out  1  serial data, MSB first.
- frame_start  out  1  one-Clk pulse at each frame boundary load.
- underrun  out  1  one-Clk pulse when a frame boundary finds no pending sample.

Behaviour:
- Reset (async, Reset=0), all registers cleared:
  - BCLK=0, LRCLK=0, SDATA=0, frame_start=0, underrun=0, sample_ready=1.
  - div_cnt=0, bit_cnt=0, pend_valid=0, active_l=active_r=0, state=IDLE.
  - Reset mid-frame aborts the frame immediately, with no completion.
- States:
  - IDLE: Enable=0. Counters held at 0; BCLK/LRCLK/SDATA=0; active registers kept.
  - RUN: Enable=1.
  - IDLE→RUN when Enable=1.
  - RUN→IDLE synchronously on the first cycle Enable=0, at any point in the frame. Counters and outputs return to their IDLE values on that edge.
- Divider (RUN):
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - On the wrap cycle BCLK toggles.
  - The first toggle after entering RUN is rising.
- Bit timing:
  - On each BCLK falling toggle, bit_cnt increments modulo 2*SLOT_BITS.
  - LRCLK and SDATA update on the same edge, from the new bit_cnt; they are stable across the following BCLK rising edge.
  - LRCLK = (bit_cnt ≥ SLOT_BITS).
  - Slot position p = bit_cnt mod SLOT_BITS.
  - SDATA = 0 for p=0 (I2S one-bit delay).
  - SDATA = word[16-p] for p=1..16, where word is active_l in the left slot and active_r in the right slot.
  - SDATA = 0 for p > 16.
- Frame boundary: the falling toggle where bit_cnt wraps from 2*SLOT_BITS-1 to 0.
  - If pend_valid: active_l/r ← pending, pend_valid ← 0.
  - Else: active registers hold their previous values (sample repeats) and underrun pulses.
  - frame_start pulses in both cases.
  - The first frame after entering RUN starts at bit_cnt=0 with no load, so it transmits the existing active registers.
- Handshake:
  - sample_ready = !pend_valid, driven from a register (no combinational path from sample_valid).
  - On a transfer: pending ← inputs, pend_valid ← 1.
  - The pending buffer accepts in IDLE as well.
  - Transfer on the same cycle as a boundary with the buffer empty: the inputs load straight into active_l/r, pend_valid stays 0, no underrun.
  - Inputs need not hold after the transfer.
- Idle data flow:
  - Dropping Enable never discards pending data.
  - Active data is retained for the next RUN.
- Timing at defaults:
  - BCLK = Clk/8.
  - Frame = 512 Clk cycles.
  - Left MSB is on SDATA from the second falling BCLK of the frame.

Test Plan:
- Reset then hold Enable=0 for 100 cycles: BCLK=LRCLK=SDATA=0 and sample_ready=1 throughout, with no frame_start pulses.
- Reset, offer L=16'h8001 and R=16'h7FFE while in IDLE, then raise Enable for two frames:
  - First frame: SDATA all zeros, ending with a frame_start pulse and no underrun.
  - Second frame, left slot: p=1..16 carry 1000000000000001, all other positions 0.
  - Second frame, right slot: 0111111111111110.
  - LRCLK high for exactly 256 Clk cycles in each frame.
- Stream 4 samples with valid tied high:
  - sample_ready falls on each transfer and rises only at the following frame_start.
  - Each sample appears in exactly one frame, in order.
- Starve the producer after L=16'h1234, R=16'hABCD: the next frame repeats 16'h1234 / 16'hABCD and underrun pulses exactly once at that boundary.
- Drop Enable mid right slot, then raise it 50 cycles later with a sample pending:
  - Outputs go to 0 on the next edge.
  - Restart at bit_cnt=0, transmitting the prior active sample; the pending sample follows in the next frame.
- Assert Reset mid-frame: all outputs clear asynchronously on the same cycle, before the next Clk edge; pend_valid is cleared.
